// File: rtl/axi4lite_reg_responder_if.sv
// AXI4-Lite bus bundle for the register responder: five channels, master and slave views.
interface axi4lite_reg_responder_if #(
  parameter int N = 4
);
  logic          AWVALID, AWREADY;
  logic [31:0]   AWADDR;
  logic [2:0]    AWPROT;
  logic          WVALID, WREADY;
  logic [8*N-1:0] WDATA;
  logic [N-1:0]  WSTRB;
  logic          BVALID, BREADY;
  logic [1:0]    BRESP;
  logic          ARVALID, ARREADY;
  logic [31:0]   ARADDR;
  logic [2:0]    ARPROT;
  logic          RVALID, RREADY;
  logic [8*N-1:0] RDATA;
  logic [1:0]    RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi4lite_reg_responder.sv
// AXI4-Lite slave exposing NUM_REGS byte-strobed registers on a flat bus, with a per-register
// write strobe. Independent write and read FSMs, each with a registered response stage.
module axi4lite_reg_responder #(
  parameter int          N         = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          NUM_REGS  = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  axi4lite_reg_responder_if.slave    bus,
  output logic [NUM_REGS*8*N-1:0]    regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse
);
  localparam int          DW   = 8 * N;
  localparam int          LSB  = $clog2(N);
  localparam int          IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] SPAN = 32'(NUM_REGS * N);
  localparam logic [1:0]  OKAY = 2'b00, DECERR = 2'b11;

  typedef enum logic { W_IDLE, W_RESP } wst_t;
  typedef enum logic { R_IDLE, R_RESP } rst_t;

  wst_t            wstate;
  rst_t            rstate;
  logic [DW-1:0]   regs [NUM_REGS];
  logic            awready, wready, bvalid, arready, rvalid;
  logic [1:0]      bresp, rresp;
  logic [DW-1:0]   rdata;
  logic            aw_have, w_have;
  logic [31:0]     awaddr_q;
  logic [DW-1:0]   wdata_q;
  logic [N-1:0]    wstrb_q;

  // Write side: the completing beat may come straight off the bus or from the holding regs.
  logic            aw_hs, w_hs, aw_got, w_got, w_hit;
  logic [31:0]     w_addr, w_off;
  logic [DW-1:0]   w_data;
  logic [N-1:0]    w_strb;
  logic [IW-1:0]   w_idx;

  assign aw_hs  = bus.AWVALID & awready;
  assign w_hs   = bus.WVALID & wready;
  assign aw_got = aw_have | aw_hs;
  assign w_got  = w_have | w_hs;
  assign w_addr = aw_hs ? bus.AWADDR : awaddr_q;
  assign w_data = w_hs ? bus.WDATA : wdata_q;
  assign w_strb = w_hs ? bus.WSTRB : wstrb_q;
  assign w_off  = w_addr - BASE_ADDR;
  assign w_hit  = w_off < SPAN;
  assign w_idx  = IW'(w_off >> LSB);

  logic            ar_hs, r_hit;
  logic [31:0]     r_off;
  logic [IW-1:0]   r_idx;

  assign ar_hs = bus.ARVALID & arready;
  assign r_off = bus.ARADDR - BASE_ADDR;
  assign r_hit = r_off < SPAN;
  assign r_idx = IW'(r_off >> LSB);

  logic unused_prot;
  assign unused_prot = ^{bus.AWPROT, bus.ARPROT};

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate   <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= OKAY;
      aw_have  <= 1'b0;
      w_have   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wr_pulse <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wr_pulse <= '0;
      case (wstate)
        W_IDLE: begin
          if (aw_hs) awaddr_q <= bus.AWADDR;
          if (w_hs) begin
            wdata_q <= bus.WDATA;
            wstrb_q <= bus.WSTRB;
          end
          if (aw_got && w_got) begin
            if (w_hit) begin
              for (int b = 0; b < N; b++)
                if (w_strb[b]) regs[w_idx][b*8 +: 8] <= w_data[b*8 +: 8];
              wr_pulse[w_idx] <= 1'b1;
            end
            bresp   <= w_hit ? OKAY : DECERR;
            bvalid  <= 1'b1;
            awready <= 1'b0;
            wready  <= 1'b0;
            aw_have <= 1'b0;
            w_have  <= 1'b0;
            wstate  <= W_RESP;
          end else begin
            // Also the path that raises the readies in the first cycle out of reset.
            aw_have <= aw_got;
            w_have  <= w_got;
            awready <= ~aw_got;
            wready  <= ~w_got;
          end
        end
        W_RESP: begin
          if (bus.BREADY) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Sampling regs with <= gives the pre-write value when a write commits at the same edge.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rdata   <= r_hit ? regs[r_idx] : '0;
            rresp   <= r_hit ? OKAY : DECERR;
            rvalid  <= 1'b1;
            arready <= 1'b0;
            rstate  <= R_RESP;
          end else begin
            arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (bus.RREADY) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            rstate  <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BRESP   = bresp;
  assign bus.ARREADY = arready;
  assign bus.RVALID  = rvalid;
  assign bus.RDATA   = rdata;
  assign bus.RRESP   = rresp;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs_o[k*DW +: DW] = regs[k];
  end
endmodule

// File: tb/tb_axi4lite_reg_responder.sv
// Directed bench for axi4lite_reg_responder: N=4, BASE_ADDR=0x1000, 16 registers.
module tb_axi4lite_reg_responder;
  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h1000;
  localparam int          NR   = 16;

  logic                ACLK = 1'b0;
  logic                ARESET;
  logic [NR*32-1:0]    regs_o;
  logic [NR-1:0]       wr_pulse;
  logic [NR*32-1:0]    exp_regs;
  int                  n_chk = 0;
  int                  n_fail = 0;

  axi4lite_reg_responder_if #(.N(N)) bus ();

  axi4lite_reg_responder #(.N(N), .BASE_ADDR(BASE), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus.slave), .regs_o(regs_o), .wr_pulse(wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input int k);
    return regs_o[k*32 +: 32];
  endfunction

  task automatic tick();
    @(negedge ACLK);
  endtask

  task automatic drive_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.AWVALID = 1'b1; bus.AWADDR = a;
    bus.WVALID  = 1'b1; bus.WDATA  = d; bus.WSTRB = s;
  endtask

  task automatic b_ack(input string tag);
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    check({tag, "_bvalid_clr"}, 64'(bus.BVALID), 64'd0);
    check({tag, "_readies"}, 64'({bus.AWREADY, bus.WREADY}), 64'b11);
    check({tag, "_pulse_clr"}, 64'(wr_pulse), 64'd0);
  endtask

  task automatic r_ack(input string tag);
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    check({tag, "_rvalid_clr"}, 64'(bus.RVALID), 64'd0);
    check({tag, "_arready"}, 64'(bus.ARREADY), 64'd1);
  endtask

  initial begin
    ARESET = 1'b1;
    bus.AWVALID = 0; bus.AWADDR = '0; bus.AWPROT = '0;
    bus.WVALID = 0;  bus.WDATA = '0;  bus.WSTRB = '0;  bus.BREADY = 0;
    bus.ARVALID = 0; bus.ARADDR = '0; bus.ARPROT = '0; bus.RREADY = 0;
    exp_regs = '0;
    repeat (3) tick();
    check("rst_readies", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'd0);
    check("rst_valids", 64'({bus.BVALID, bus.RVALID}), 64'd0);
    check("rst_regs", 64'(regs_o == '0), 64'd1);
    ARESET = 1'b0;
    tick();
    check("post_rst_readies", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'b111);

    // 1: AW and W together to reg2
    drive_w(BASE + 32'h8, 32'hDEADBEEF, 4'hF);
    tick();
    bus.AWVALID = 0; bus.WVALID = 0;
    check("t1_bvalid", 64'(bus.BVALID), 64'd1);
    check("t1_bresp", 64'(bus.BRESP), 64'd0);
    check("t1_pulse", 64'(wr_pulse), 64'h0004);
    check("t1_reg2", 64'(reg_of(2)), 64'hDEADBEEF);
    check("t1_readies_low", 64'({bus.AWREADY, bus.WREADY}), 64'd0);
    b_ack("t1");

    // 2: W leads AW by 3 cycles, partial strobes to reg1
    bus.WVALID = 1; bus.WDATA = 32'h11223344; bus.WSTRB = 4'h5;
    tick();
    bus.WVALID = 0;
    check("t2_wready_low", 64'(bus.WREADY), 64'd0);
    check("t2_awready_hi", 64'(bus.AWREADY), 64'd1);
    tick();
    tick();
    check("t2_wready_still_low", 64'(bus.WREADY), 64'd0);
    check("t2_no_bvalid", 64'(bus.BVALID), 64'd0);
    bus.AWVALID = 1; bus.AWADDR = BASE + 32'h4;
    tick();
    bus.AWVALID = 0;
    check("t2_bvalid", 64'(bus.BVALID), 64'd1);
    check("t2_reg1", 64'(reg_of(1)), 64'h00220044);
    check("t2_pulse", 64'(wr_pulse), 64'h0002);
    b_ack("t2");

    // 3: read reg2 with RREADY held off 4 cycles
    bus.ARVALID = 1; bus.ARADDR = BASE + 32'h8;
    tick();
    bus.ARVALID = 0;
    for (int i = 0; i < 4; i++) begin
      check("t3_hold", 64'({bus.RVALID, bus.ARREADY, bus.RRESP, bus.RDATA}),
            {28'd0, 1'b1, 1'b0, 2'b00, 32'hDEADBEEF});
      tick();
    end
    r_ack("t3");

    // 4: out-of-range write+read, then read below base
    exp_regs[2*32 +: 32] = 32'hDEADBEEF;
    exp_regs[1*32 +: 32] = 32'h00220044;
    drive_w(BASE + 32'(NR*N), 32'hFFFFFFFF, 4'hF);
    bus.ARVALID = 1; bus.ARADDR = BASE + 32'(NR*N);
    tick();
    bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
    check("t4_bresp", 64'({bus.BVALID, bus.BRESP}), 64'b111);
    check("t4_no_pulse", 64'(wr_pulse), 64'd0);
    check("t4_regs", 64'(regs_o == exp_regs), 64'd1);
    check("t4_rd", 64'({bus.RVALID, bus.RRESP, bus.RDATA}), {29'd0, 1'b1, 2'b11, 32'd0});
    b_ack("t4");
    r_ack("t4");
    bus.ARVALID = 1; bus.ARADDR = BASE - 32'd4;
    tick();
    bus.ARVALID = 0;
    check("t4_below", 64'({bus.RVALID, bus.RRESP, bus.RDATA}), {29'd0, 1'b1, 2'b11, 32'd0});
    r_ack("t4b");

    // 6: write commit and read capture of reg3 at the same edge
    drive_w(BASE + 32'hC, 32'hA5A5A5A5, 4'hF);
    tick();
    bus.AWVALID = 0; bus.WVALID = 0;
    check("t6_pre_reg3", 64'(reg_of(3)), 64'hA5A5A5A5);
    b_ack("t6a");
    drive_w(BASE + 32'hC, 32'h12345678, 4'hF);
    bus.ARVALID = 1; bus.ARADDR = BASE + 32'hC;
    tick();
    bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
    check("t6_old_data", 64'(bus.RDATA), 64'hA5A5A5A5);
    check("t6_new_reg3", 64'(reg_of(3)), 64'h12345678);
    check("t6_pulse", 64'(wr_pulse), 64'h0008);

    // 5: reset with both responses pending
    check("t5_pending", 64'({bus.BVALID, bus.RVALID}), 64'b11);
    ARESET = 1'b1;
    tick();
    check("t5_valids", 64'({bus.BVALID, bus.RVALID}), 64'd0);
    check("t5_regs", 64'(regs_o == '0), 64'd1);
    check("t5_readies_low", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'd0);
    check("t5_rdata", 64'({bus.RDATA, bus.RRESP, bus.BRESP}), 64'd0);
    ARESET = 1'b0;
    tick();
    check("t5_readies", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
